// File: rtl/aes_round_sequencer.sv
// Round sequencer for the AES cores. It steps the shared round datapath through 10/12/14
// rounds in either direction and handshakes blocks in and out with valid/ready.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 128
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic              abort,
    input  logic              key_ready,
    output logic [3:0]        round_idx,
    output logic              mode_q,
    output logic              state_load,
    output logic              sub_en,
    output logic              shift_en,
    output logic              mix_en,
    output logic              add_en,
    input  logic [DATA_W-1:0] datapath_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT_ADD,
        ROUND,
        FINAL,
        CAPTURE,
        OUT
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t              state_q;
    logic [3:0]          round_q;
    logic                outValid_q;
    logic [DATA_W-1:0]   dataOut_q;
    logic                unused_data_in;

    // The datapath loads data_in itself; the sequencer only tells it when.
    assign unused_data_in = ^data_in;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = outValid_q;
    assign data_out  = dataOut_q;
    assign round_idx = mode_q ? (LAST_ROUND - round_q) : round_q;

    // Stage enables follow the current state and are suppressed while waiting for a key or aborting.
    always_comb begin
        state_load = 1'b0;
        sub_en     = 1'b0;
        shift_en   = 1'b0;
        mix_en     = 1'b0;
        add_en     = 1'b0;
        if (!abort) begin
            case (state_q)
                LOAD: begin
                    state_load = 1'b1;
                end
                INIT_ADD: begin
                    add_en = key_ready;
                end
                ROUND: begin
                    sub_en   = key_ready;
                    shift_en = key_ready;
                    mix_en   = key_ready;
                    add_en   = key_ready;
                end
                FINAL: begin
                    sub_en   = key_ready;
                    shift_en = key_ready;
                    add_en   = key_ready;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            round_q    <= 4'd0;
            mode_q     <= 1'b0;
            outValid_q <= 1'b0;
            dataOut_q  <= '0;
        end else if (abort && state_q != IDLE) begin
            state_q    <= IDLE;
            round_q    <= 4'd0;
            outValid_q <= 1'b0;
            dataOut_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mode_q  <= mode;
                        round_q <= 4'd0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= INIT_ADD;
                end
                INIT_ADD: begin
                    if (key_ready) begin
                        round_q <= 4'd1;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    // The last full round leaves the counter at NUM_ROUNDS for the final round key.
                    if (key_ready) begin
                        round_q <= round_q + 4'd1;
                        if (round_q == LAST_ROUND - 4'd1) begin
                            state_q <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    if (key_ready) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    dataOut_q  <= datapath_in;
                    outValid_q <= 1'b1;
                    state_q    <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
